// File: rtl/sad_pkg.sv
// Shared constants for the SAD pattern trigger: register map, threshold width, trigger latency.
// Imported by sad_reg_if and sad_trigger_wrapper.
package sad_pkg;

  localparam logic [7:0] SAD_REFERENCE         = 8'h30;
  localparam logic [7:0] SAD_REFEN             = 8'h31;
  localparam logic [7:0] SAD_THRESHOLD         = 8'h32;
  localparam logic [7:0] SAD_MULTIPLE_TRIGGERS = 8'h33;
  localparam logic [7:0] SAD_STATUS            = 8'h34;

  localparam int SAD_TH_WIDTH = 32;
  localparam int SAD_LATENCY  = 6;

endpackage

// File: rtl/sad_reg_if.sv
// Register bus for the SAD trigger: address decode, auto-incrementing byte index, config storage, read mux.
// Writes land on the WRn rising edge and apply from the next clock; reads are combinational while RDn/CEn are low.
module sad_reg_if
  import sad_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREF_SAMPLES  = 8
) (
  input  logic                          clk_adc,
  input  logic                          reset,
  input  logic [7:0]                    wr_dat,
  output logic [7:0]                    rd_dat,
  output logic                          rd_oe,
  input  logic [7:0]                    USB_Addr,
  input  logic                          USB_RDn,
  input  logic                          USB_WRn,
  input  logic                          USB_CEn,
  input  logic                          USB_ALEn,
  input  logic                          status_flag,
  input  logic [7:0]                    status_cnt,
  output logic [pREF_SAMPLES-1:0][7:0]  ref_bytes,
  output logic [pREF_SAMPLES-1:0]       refen,
  output logic [SAD_TH_WIDTH-1:0]       threshold,
  output logic                          multi_trig
);

  localparam int EN_BYTES = pREF_SAMPLES / 8;

  logic [pBYTECNT_SIZE-1:0] idx;
  logic [7:0]               addr_q;
  logic [7:0]               wdat_q;
  logic                     rdn_q;
  logic                     wrn_q;
  logic                     wr_stb;
  logic                     rd_stb;

  assign wr_stb = !wrn_q && USB_WRn && !USB_CEn;
  assign rd_stb = !rdn_q && USB_RDn && !USB_CEn;
  assign rd_oe  = !USB_RDn && !USB_CEn;

  // Data is held from the low phase of WRn so the rising edge can commit it.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      idx        <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      ref_bytes  <= '0;
      refen      <= '0;
      threshold  <= '0;
      multi_trig <= 1'b0;
    end else begin
      addr_q <= USB_Addr;
      rdn_q  <= USB_RDn;
      wrn_q  <= USB_WRn;
      if (!USB_WRn) wdat_q <= wr_dat;
      if (!USB_ALEn || (USB_Addr != addr_q)) idx <= '0;
      else if (wr_stb || rd_stb)             idx <= idx + 1'b1;
      if (wr_stb) begin
        case (USB_Addr)
          SAD_REFERENCE:
            for (int k = 0; k < pREF_SAMPLES; k++)
              if (int'(idx) == k) ref_bytes[k] <= wdat_q;
          SAD_REFEN:
            for (int k = 0; k < EN_BYTES; k++)
              if (int'(idx) == k) refen[k*8 +: 8] <= wdat_q;
          SAD_THRESHOLD:
            for (int k = 0; k < SAD_TH_WIDTH / 8; k++)
              if (int'(idx) == k) threshold[k*8 +: 8] <= wdat_q;
          SAD_MULTIPLE_TRIGGERS:
            if (idx == '0) multi_trig <= wdat_q[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    case (USB_Addr)
      SAD_REFERENCE:
        for (int k = 0; k < pREF_SAMPLES; k++)
          if (int'(idx) == k) rd_dat = ref_bytes[k];
      SAD_REFEN:
        for (int k = 0; k < EN_BYTES; k++)
          if (int'(idx) == k) rd_dat = refen[k*8 +: 8];
      SAD_THRESHOLD:
        for (int k = 0; k < SAD_TH_WIDTH / 8; k++)
          if (int'(idx) == k) rd_dat = threshold[k*8 +: 8];
      SAD_MULTIPLE_TRIGGERS:
        if (idx == '0) rd_dat = {7'd0, multi_trig};
      SAD_STATUS: begin
        if (idx == '0)          rd_dat = {7'd0, status_flag};
        else if (int'(idx) == 1) rd_dat = status_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sad_trigger_wrapper.sv
// SAD pattern trigger: sliding window of ADC samples vs a reference; trigger rises 6 clocks after the last window sample.
// One sample per clock, no backpressure; define SAD_TRIG_STRETCH_EN to widen each trigger pulse to two cycles.
module sad_trigger_wrapper
  import sad_pkg::*;
#(
  parameter int pBYTECNT_SIZE    = 7,
  parameter int pREF_SAMPLES     = 8,
  parameter int pBITS_PER_SAMPLE = 8
) (
  input  logic        clk_adc,
  input  logic        reset,
  input  logic [11:0] adc_datain,
  input  logic        armed_and_ready,
  inout  wire  [7:0]  USB_Data,
  input  logic [7:0]  USB_Addr,
  input  logic        USB_RDn,
  input  logic        USB_WRn,
  input  logic        USB_CEn,
  input  logic        USB_ALEn,
  output logic        trigger
);

  localparam int N  = pREF_SAMPLES;
  localparam int B  = pBITS_PER_SAMPLE;
  localparam int G  = N / 8;
  localparam int GW = B + 3;
  localparam int FW = $clog2(N + 1);

  logic [7:0]              rd_dat;
  logic                    rd_oe;
  logic [N-1:0][7:0]       ref_bytes;
  logic [N-1:0]            refen;
  logic [SAD_TH_WIDTH-1:0] threshold;
  logic                    multi_trig;

  logic [N-1:0][B-1:0]     hist;
  logic [FW-1:0]           fill;
  logic [N-1:0][B-1:0]     diff_c, diff1;
  logic [G-1:0][GW-1:0]    grp_c, grp2;
  logic [SAD_TH_WIDTH-1:0] tot_c, sum3, th1, th2, th3;
  logic                    v1, v2, v3, hit4, hit5;
  logic                    m1, m2, m3, m4, m5;
  logic                    armed_q, arm_rise, trig_set, trig_q, flag;
  logic [7:0]              cnt;
  logic                    unused_bits;

  assign USB_Data    = rd_oe ? rd_dat : 8'bz;
  assign unused_bits = ^{adc_datain, ref_bytes};

  sad_reg_if #(
    .pBYTECNT_SIZE (pBYTECNT_SIZE),
    .pREF_SAMPLES  (pREF_SAMPLES)
  ) u_reg_if (
    .clk_adc     (clk_adc),
    .reset       (reset),
    .wr_dat      (USB_Data),
    .rd_dat      (rd_dat),
    .rd_oe       (rd_oe),
    .USB_Addr    (USB_Addr),
    .USB_RDn     (USB_RDn),
    .USB_WRn     (USB_WRn),
    .USB_CEn     (USB_CEn),
    .USB_ALEn    (USB_ALEn),
    .status_flag (flag),
    .status_cnt  (cnt),
    .ref_bytes   (ref_bytes),
    .refen       (refen),
    .threshold   (threshold),
    .multi_trig  (multi_trig)
  );

  // Three pipelined reduction levels: masked |diff|, sums of 8, grand total.
  always_comb begin
    diff_c = '0;
    grp_c  = '0;
    tot_c  = '0;
    for (int i = 0; i < N; i++)
      if (refen[i])
        diff_c[i] = (hist[i] > ref_bytes[i][B-1:0]) ? hist[i] - ref_bytes[i][B-1:0]
                                                    : ref_bytes[i][B-1:0] - hist[i];
    for (int g = 0; g < G; g++)
      for (int j = 0; j < 8; j++)
        grp_c[g] = grp_c[g] + GW'(diff1[g*8+j]);
    for (int g = 0; g < G; g++)
      tot_c = tot_c + SAD_TH_WIDTH'(grp2[g]);
  end

  assign arm_rise = armed_and_ready && !armed_q;
  assign trig_set = armed_and_ready && hit5 && (m5 || !flag);

  // Threshold and multi-trigger mode travel with the window so later writes don't affect it.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      hist <= '0; fill <= '0; diff1 <= '0; grp2 <= '0; sum3 <= '0;
      th1 <= '0; th2 <= '0; th3 <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; hit4 <= 1'b0; hit5 <= 1'b0;
      m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0; m4 <= 1'b0; m5 <= 1'b0;
      armed_q <= 1'b0; trig_q <= 1'b0; flag <= 1'b0; cnt <= '0;
    end else begin
      armed_q <= armed_and_ready;
      if (armed_and_ready) begin
        hist <= {adc_datain[11 -: B], hist[N-1:1]};
        fill <= (fill == FW'(N)) ? fill : fill + 1'b1;
      end else begin
        fill <= '0;
      end
      diff1 <= diff_c;  th1 <= threshold; m1 <= multi_trig;
      v1    <= armed_and_ready && (fill == FW'(N));
      grp2  <= grp_c;   th2 <= th1;       m2 <= m1;
      v2    <= armed_and_ready && v1;
      sum3  <= tot_c;   th3 <= th2;       m3 <= m2;
      v3    <= armed_and_ready && v2;
      hit4  <= armed_and_ready && v3 && (sum3 < th3);
      m4    <= m3;
      hit5  <= armed_and_ready && hit4;
      m5    <= m4;
      trig_q <= trig_set;
      if (arm_rise) begin
        flag <= 1'b0;
        cnt  <= '0;
      end else if (trig_set) begin
        flag <= 1'b1;
        if (cnt != 8'hFF) cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SAD_TRIG_STRETCH_EN
  logic trig_d;
  always_ff @(posedge clk_adc) begin
    if (reset) trig_d <= 1'b0;
    else       trig_d <= trig_q && armed_and_ready;
  end
  assign trigger = trig_q | trig_d;
`else
  assign trigger = trig_q;
`endif

endmodule

// File: tb/tb_sad_trigger_wrapper.sv
// Randomized bench for sad_trigger_wrapper: queue-based SAD reference model, per-cycle trigger check, scenario checks.
module tb_sad_trigger_wrapper;
  import sad_pkg::*;

  localparam int N = 8;

  logic        clk_adc = 1'b0;
  logic        reset;
  logic [11:0] adc_datain;
  logic        armed_and_ready;
  wire  [7:0]  USB_Data;
  logic [7:0]  USB_Addr;
  logic        USB_RDn, USB_WRn, USB_CEn, USB_ALEn;
  logic        trigger;
  logic [7:0]  drv_dat;
  logic        drv_en;

  assign USB_Data = drv_en ? drv_dat : 8'bz;

  always #5 clk_adc = ~clk_adc;

  sad_trigger_wrapper dut (
    .clk_adc         (clk_adc),
    .reset           (reset),
    .adc_datain      (adc_datain),
    .armed_and_ready (armed_and_ready),
    .USB_Data        (USB_Data),
    .USB_Addr        (USB_Addr),
    .USB_RDn         (USB_RDn),
    .USB_WRn         (USB_WRn),
    .USB_CEn         (USB_CEn),
    .USB_ALEn        (USB_ALEn),
    .trigger         (trigger)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register shadow kept by the bench
  logic [7:0]   ref_m [N];
  logic [N-1:0] en_m;
  logic [31:0]  thr_m;
  logic         mult_m;

  // Reference model: window of captured samples, scheduled matches
  typedef struct { int due; bit m; } pend_t;
  pend_t      pend [$];
  logic [7:0] win [$];
  int         cyc = 0;
  bit         mflag, exp_trig, exp_prev, m_armed_q;
  int         mcnt;

  function automatic longint window_sad();
    longint s = 0;
    for (int i = 0; i < N; i++)
      if (en_m[i]) s += (win[i] > ref_m[i]) ? longint'(win[i] - ref_m[i]) : longint'(ref_m[i] - win[i]);
    return s;
  endfunction

  always @(posedge clk_adc) begin
    if (reset) begin
      win.delete(); pend.delete();
      mflag = 0; mcnt = 0; exp_trig = 0; exp_prev = 0; m_armed_q = 0;
    end else begin
      exp_prev = exp_trig && armed_and_ready;
      exp_trig = 0;
      if (armed_and_ready && !m_armed_q) begin mflag = 0; mcnt = 0; end
      if (!armed_and_ready) begin
        win.delete(); pend.delete();
      end else begin
        if (pend.size() > 0 && pend[0].due == cyc) begin
          if (pend[0].m || !mflag) begin
            exp_trig = 1; mflag = 1;
            if (mcnt < 255) mcnt++;
          end
          void'(pend.pop_front());
        end
        win.push_back(adc_datain[11:4]);
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N && window_sad() < longint'(thr_m))
          pend.push_back('{cyc + SAD_LATENCY, mult_m});
      end
      m_armed_q = armed_and_ready;
    end
    cyc++;
  end

  bit chk_en = 0;
  bit obs_prev = 0;
  int obs_pulses = 0;
  int first_trig = -1;
  int last_drive = 0;

  always @(negedge clk_adc) begin
    if (chk_en) begin
`ifdef SAD_TRIG_STRETCH_EN
      check($sformatf("trig@%0d", cyc - 1), 32'(trigger), 32'(exp_trig | exp_prev));
`else
      check($sformatf("trig@%0d", cyc - 1), 32'(trigger), 32'(exp_trig));
`endif
      if (trigger && !obs_prev) begin
        obs_pulses++;
        if (first_trig < 0) first_trig = cyc - 1;
      end
      obs_prev = trigger;
    end
  end

  task automatic tick();
    @(negedge clk_adc);
  endtask

  task automatic bus_write(input logic [7:0] addr, input int nb, input logic [63:0] val);
    USB_Addr = addr; USB_ALEn = 0; tick();
    USB_ALEn = 1; USB_CEn = 0; tick();
    for (int i = 0; i < nb; i++) begin
      drv_dat = val[i*8 +: 8]; drv_en = 1; USB_WRn = 0; tick();
      USB_WRn = 1; tick();
    end
    drv_en = 0; USB_CEn = 1; tick();
  endtask

  task automatic bus_read(input logic [7:0] addr, input int nb, output logic [63:0] val);
    val = '0;
    USB_Addr = addr; USB_ALEn = 0; tick();
    USB_ALEn = 1; USB_CEn = 0; tick();
    for (int i = 0; i < nb; i++) begin
      USB_RDn = 0; tick();
      val[i*8 +: 8] = USB_Data;
      USB_RDn = 1; tick();
    end
    USB_CEn = 1; tick();
  endtask

  task automatic set_regs(input logic [63:0] rv, input logic [7:0] en, input logic [31:0] t, input bit m);
    for (int i = 0; i < N; i++) ref_m[i] = rv[i*8 +: 8];
    en_m = en; thr_m = t; mult_m = m;
    bus_write(SAD_REFERENCE, N, rv);
    bus_write(SAD_REFEN, 1, {56'd0, en});
    bus_write(SAD_THRESHOLD, 4, {32'd0, t});
    bus_write(SAD_MULTIPLE_TRIGGERS, 1, {63'd0, m});
  endtask

  task automatic check_all_zero(input string tag);
    logic [63:0] v;
    bus_read(SAD_REFERENCE, N, v);          check({tag, "_ref"}, v[31:0], 0); check({tag, "_ref_hi"}, v[63:32], 0);
    bus_read(SAD_REFEN, 1, v);              check({tag, "_refen"}, v[31:0], 0);
    bus_read(SAD_THRESHOLD, 4, v);          check({tag, "_thr"}, v[31:0], 0);
    bus_read(SAD_MULTIPLE_TRIGGERS, 1, v);  check({tag, "_mult"}, v[31:0], 0);
    bus_read(SAD_STATUS, 2, v);             check({tag, "_status"}, v[31:0], 0);
  endtask

  task automatic feed(input logic [7:0] b);
    adc_datain = {b, 4'($urandom)};
    last_drive = cyc;
    tick();
  endtask

  task automatic feed_rand(input int n);
    for (int i = 0; i < n; i++) feed(8'($urandom));
  endtask

  // Reference pattern with total deviation dev spread over samples lo..hi; kill0 wrecks sample 0.
  task automatic feed_pattern(input int dev, input bit kill0, input int lo, input int hi);
    int dv;
    logic [7:0] b;
    for (int i = lo; i <= hi; i++) begin
      dv = dev / N + ((i < dev % N) ? 1 : 0);
      b = (ref_m[i] < 8'd128) ? ref_m[i] + 8'(dv) : ref_m[i] - 8'(dv);
      if (kill0 && i == 0) b = ref_m[0] ^ 8'h80;
      feed(b);
    end
  endtask

  task automatic check_status(input string tag, input int flag, input int count);
    logic [63:0] v;
    bus_read(SAD_STATUS, 2, v);
    check({tag, "_flag"}, v[7:0], 32'(flag));
    check({tag, "_cnt"}, v[15:8], 32'(count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] rv, v;
    reset = 1; armed_and_ready = 0; adc_datain = '0;
    USB_Addr = '0; USB_RDn = 1; USB_WRn = 1; USB_CEn = 1; USB_ALEn = 1;
    drv_en = 0; drv_dat = '0;
    for (int i = 0; i < N; i++) ref_m[i] = '0;
    en_m = '0; thr_m = '0; mult_m = 0;
    repeat (3) tick();
    reset = 0; tick();
    chk_en = 1;
    check("rst_trig", 32'(trigger), 0);
    check_all_zero("rst");

    // Register access: readback, undefined address, writes past register length
    rv = {$urandom, $urandom};
    set_regs(rv, 8'hFF, 32'd100, 0);
    bus_read(SAD_REFERENCE, N, v);      check("rb_ref", v[31:0], rv[31:0]); check("rb_ref_hi", v[63:32], rv[63:32]);
    bus_read(SAD_THRESHOLD, 5, v);      check("rb_thr", v[31:0], 100); check("rb_thr_past", v[39:32], 0);
    bus_read(SAD_REFEN, 1, v);          check("rb_refen", v[7:0], 8'hFF);
    bus_write(8'h10, 1, 64'h55);
    bus_read(8'h10, 1, v);              check("undef_rd", v[7:0], 0);
    bus_write(SAD_MULTIPLE_TRIGGERS, 2, 64'hAAFF);
    bus_read(SAD_MULTIPLE_TRIGGERS, 2, v); check("mult_past", v[15:0], 16'h0001);
    bus_write(SAD_MULTIPLE_TRIGGERS, 1, 64'h0);

    // Scenario 1: exact pattern right after arm
    obs_pulses = 0; first_trig = -1;
    armed_and_ready = 1;
    feed_pattern(0, 0, 0, N - 1);
    begin
      int e_cyc;
      e_cyc = last_drive;
      feed_rand(12);
      check("s1_latency", 32'(first_trig - e_cyc), 6);
    end
    armed_and_ready = 0; tick();
    check("s1_pulses", 32'(obs_pulses), 1);
    check_status("s1", 1, 1);

    // Scenario 2: deviation equal to T must not match, one below must
    obs_pulses = 0;
    armed_and_ready = 1;
    feed_rand(5);
    feed_pattern(100, 0, 0, N - 1);
    feed_rand(12);
    check("s2_dev100", 32'(obs_pulses), 0);
    feed_pattern(99, 0, 0, N - 1);
    feed_rand(12);
    armed_and_ready = 0; tick();
    check("s2_dev99", 32'(obs_pulses), 1);
    check_status("s2", 1, 1);

    // Scenario 3: multi-trigger mode
    bus_write(SAD_MULTIPLE_TRIGGERS, 1, 64'h1); mult_m = 1;
    obs_pulses = 0;
    armed_and_ready = 1;
    feed_rand(4);
    feed_pattern(0, 0, 0, N - 1);
    feed_rand(30 + $urandom_range(0, 10));
    feed_pattern(0, 0, 0, N - 1);
    feed_rand(12);
    armed_and_ready = 0; tick();
    check("s3_pulses", 32'(obs_pulses), 2);
    check_status("s3", 1, 2);

    // Scenario 4: single-trigger mode, re-arm re-enables
    bus_write(SAD_MULTIPLE_TRIGGERS, 1, 64'h0); mult_m = 0;
    obs_pulses = 0;
    armed_and_ready = 1;
    feed_pattern(0, 0, 0, N - 1);
    feed_rand(30 + $urandom_range(0, 10));
    feed_pattern(0, 0, 0, N - 1);
    feed_rand(12);
    armed_and_ready = 0; tick();
    check("s4_first_arm", 32'(obs_pulses), 1);
    repeat (3) tick();
    armed_and_ready = 1;
    feed_rand(8);
    feed_pattern(0, 0, 0, N - 1);
    feed_rand(12);
    armed_and_ready = 0; tick();
    check("s4_rearm", 32'(obs_pulses), 2);
    check_status("s4", 1, 1);

    // Scenario 5: sample 0 disabled, its value must not matter
    bus_write(SAD_REFEN, 1, 64'hFE); en_m = 8'hFE;
    bus_write(SAD_MULTIPLE_TRIGGERS, 1, 64'h1); mult_m = 1;
    obs_pulses = 0;
    armed_and_ready = 1;
    for (int r = 0; r < 3; r++) begin
      feed_rand(20);
      feed_pattern(0, 1, 0, N - 1);
    end
    feed_rand(12);
    armed_and_ready = 0; tick();
    check("s5_pulses", 32'(obs_pulses), 3);
    check_status("s5", 1, 3);

    // Scenario 6: window not full after arm, then reset mid-window
    bus_write(SAD_REFEN, 1, 64'hFF); en_m = 8'hFF;
    obs_pulses = 0;
    feed_pattern(0, 0, 0, N - 4);
    armed_and_ready = 1;
    feed_pattern(0, 0, N - 3, N - 1);
    feed_rand(12);
    check("s6_not_full", 32'(obs_pulses), 0);
    feed_pattern(0, 0, 0, 3);
    reset = 1;
    for (int i = 0; i < N; i++) ref_m[i] = '0;
    en_m = '0; thr_m = '0; mult_m = 0;
    tick();
    check("s6_rst_trig", 32'(trigger), 0);
    reset = 0; armed_and_ready = 0; tick();
    check_all_zero("s6");

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
